// File: rtl/program_loader.sv
// program_loader: streams an instruction segment followed by a data segment
// from a valid/ready source into the processor's loading port, then holds the
// processor's run enable until it reports completion.
module program_loader #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64,
    parameter int CNT_W      = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic [31:0]      new_instruction,
    output logic             add_into,
    output logic             wr_en,
    output logic [CNT_W-1:0] wr_addr,
    output logic             start_signal,
    input  logic             end_signal,
    output logic             busy,
    output logic             error,
    output logic [CNT_W-1:0] i_count,
    output logic [CNT_W-1:0] d_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        GAP,
        LOAD_D,
        RUN,
        DONE,
        ERR
    } state_t;

    // Count value at which a word without in_last fills the segment.
    localparam logic [CNT_W-1:0] I_FULL = CNT_W'(IMEM_DEPTH - 1);
    localparam logic [CNT_W-1:0] D_FULL = CNT_W'(DMEM_DEPTH - 1);

    state_t state;
    state_t state_next;
    logic   xfer;
    logic   go_accept;

    assign in_ready     = (state == LOAD_I) || (state == LOAD_D);
    assign xfer         = in_valid && in_ready;
    assign go_accept    = go && ((state == IDLE) || (state == DONE) || (state == ERR));
    assign busy         = (state == LOAD_I) || (state == GAP) || (state == LOAD_D) || (state == RUN);
    // Run enable and error flag are direct state decodes; they change on the
    // same edge that enters or leaves RUN / ERR.
    assign start_signal = (state == RUN);
    assign error        = (state == ERR);

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: segment sequencing and overflow detection.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (go) begin
                    state_next = LOAD_I;
                end
            end
            LOAD_I: begin
                if (xfer) begin
                    if (in_last) begin
                        state_next = GAP;
                    end else if (i_count == I_FULL) begin
                        state_next = ERR;
                    end
                end
            end
            GAP: begin
                state_next = LOAD_D;
            end
            LOAD_D: begin
                if (xfer) begin
                    if (in_last) begin
                        state_next = RUN;
                    end else if (d_count == D_FULL) begin
                        state_next = ERR;
                    end
                end
            end
            RUN: begin
                if (end_signal) begin
                    state_next = DONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write port, segment select and word counters, all registered so a
    // transfer appears on the loading interface one cycle later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            new_instruction <= '0;
            wr_en           <= 1'b0;
            wr_addr         <= '0;
            add_into        <= 1'b0;
            i_count         <= '0;
            d_count         <= '0;
        end else begin
            wr_en <= xfer;
            if (xfer) begin
                new_instruction <= in_data;
                if (state == LOAD_I) begin
                    wr_addr <= i_count;
                    i_count <= i_count + CNT_W'(1);
                end else begin
                    wr_addr <= d_count;
                    d_count <= d_count + CNT_W'(1);
                end
            end
            if (state == GAP) begin
                add_into <= 1'b1;
            end
            if (go_accept) begin
                i_count  <= '0;
                d_count  <= '0;
                add_into <= 1'b0;
            end
        end
    end

endmodule
